// File: rtl/tb_mem_ctrl.sv
// tb_mem_ctrl: strobed, stall-injecting, fixed-latency memory port in front of a single-port SRAM
module tb_mem_ctrl #(
    parameter int NumWords    = 256,
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 12,
    parameter int RespLatency = 1,
    parameter int StallEvery  = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic [AddrWidth-1:0]        addr_i,
    input  logic                        we_i,
    input  logic [DataWidth-1:0]        wdata_i,
    input  logic [DataWidth/8-1:0]      strb_i,
    output logic                        rvalid_o,
    output logic [DataWidth-1:0]        rdata_o,
    output logic                        sram_req_o,
    output logic                        sram_we_o,
    output logic [$clog2(NumWords)-1:0] sram_addr_o,
    output logic [DataWidth-1:0]        sram_wdata_o,
    output logic [DataWidth/8-1:0]      sram_be_o,
    input  logic [DataWidth-1:0]        sram_rdata_i,
    output logic                        oor_o,
    output logic [31:0]                 req_cnt_o
);
    localparam int OFF = $clog2(DataWidth/8);
    localparam int WW  = AddrWidth - OFF;
    localparam int SAW = $clog2(NumWords);
    localparam int SW  = StallEvery > 1 ? $clog2(StallEvery) : 1;
    localparam int RL  = RespLatency;

    if (StallEvery == 1 || RespLatency < 1 || RespLatency > 8) begin : g_bad_param
        $fatal(1, "tb_mem_ctrl: StallEvery must not be 1 and RespLatency must be 1..8");
    end

    logic [SW-1:0]        stall_cnt_q, stall_cnt_d;
    logic [RL-1:0]        vld_q, vld_d, wr_q, wr_d, oor_pipe_q, oor_pipe_d;
    logic                 oor_q, oor_d;
    logic [31:0]          req_cnt_q, req_cnt_d;
    logic [WW-1:0]        waddr;
    logic                 in_range, fire, stall;
    logic [DataWidth-1:0] pipe_rdata;
    logic                 unused_addr;

    assign unused_addr = ^addr_i;

    always_comb begin
        stall        = StallEvery != 0 && stall_cnt_q == SW'(StallEvery - 1);
        gnt_o        = rst_ni && !stall;
        waddr        = addr_i[AddrWidth-1:OFF];
        in_range     = 32'(waddr) < NumWords;
        fire         = req_i && gnt_o;
        sram_req_o   = fire && in_range;
        sram_we_o    = sram_req_o && we_i;
        sram_addr_o  = waddr[SAW-1:0];
        sram_wdata_o = wdata_i;
        sram_be_o    = we_i ? strb_i : '1;
        stall_cnt_d  = (StallEvery == 0 || stall) ? '0 : stall_cnt_q + SW'(1);
        vld_d        = (vld_q << 1) | RL'(fire);
        wr_d         = (wr_q << 1) | RL'(fire && we_i);
        oor_pipe_d   = (oor_pipe_q << 1) | RL'(fire && !in_range);
        oor_d        = oor_q || (fire && !in_range);
        req_cnt_d    = (fire && !(&req_cnt_q)) ? req_cnt_q + 32'd1 : req_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            vld_q       <= '0;
            wr_q        <= '0;
            oor_pipe_q  <= '0;
            oor_q       <= 1'b0;
            req_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            vld_q       <= vld_d;
            wr_q        <= wr_d;
            oor_pipe_q  <= oor_pipe_d;
            oor_q       <= oor_d;
            req_cnt_q   <= req_cnt_d;
        end
    end

    // SRAM data arrives with stage 1; only the remaining RL-1 stages need registers
    if (RL == 1) begin : g_data_direct
        assign pipe_rdata = sram_rdata_i;
    end else begin : g_data_pipe
        logic [DataWidth-1:0] dat_q [RL-1];
        logic [DataWidth-1:0] dat_d [RL-1];
        always_comb begin
            dat_d[0] = vld_q[0] ? sram_rdata_i : dat_q[0];
            for (int i = 1; i < RL - 1; i++) dat_d[i] = dat_q[i-1];
        end
        always_ff @(posedge clk_i) begin
            for (int i = 0; i < RL - 1; i++) dat_q[i] <= rst_ni ? dat_d[i] : '0;
        end
        assign pipe_rdata = dat_q[RL-2];
    end

    assign rvalid_o  = vld_q[RL-1];
    assign rdata_o   = (!vld_q[RL-1] || wr_q[RL-1]) ? '0 :
                       oor_pipe_q[RL-1] ? DataWidth'(32'hDEAD_BEEF) : pipe_rdata;
    assign oor_o     = oor_q;
    assign req_cnt_o = req_cnt_q;
endmodule

// File: doc/tb_mem_ctrl.md
# tb_mem_ctrl

Testbench-side memory controller between the `axi_to_mem` memory port and the single-port `sram_wrapper` behind the external AXI slave of `x_alp`. Applies byte strobes to the SRAM and enforces a configurable grant-stall pattern and fixed response latency. Every granted request, read or write, gets exactly one `rvalid` pulse. It also flags out-of-range accesses and counts traffic. This gives the harness a memory that exercises backpressure and strobes, instead of an always-grant, full-word-write RAM.

## Interface
- `NumWords`, 256: SRAM depth in words.
- `DataWidth`, 64: data width in bits; multiple of 8.
- `AddrWidth`, 12: byte-address width on the upstream side; must satisfy `2**AddrWidth >= NumWords*DataWidth/8`.
- `RespLatency`, 1: cycles from grant to `rvalid_o`; legal values 1..8.
- `StallEvery`, 0: grant-stall period. 0 means never stall; N>=2 means `gnt_o` is low one cycle in every N. The value 1 is illegal and is rejected by an elaboration assertion.
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `req_i` in 1: upstream request.
- `gnt_o` out 1: grant. A transfer occurs when `req_i && gnt_o`.
- `addr_i` in AddrWidth: byte address.
- `we_i` in 1: write enable.
- `wdata_i` in DataWidth: write data.
- `strb_i` in DataWidth/8: byte strobes.
- `rvalid_o` out 1: response valid, one pulse per granted request.
- `rdata_o` out DataWidth: read data. Zero on write responses; `32'hDEAD_BEEF`, zero-extended, on out-of-range reads.
- `sram_req_o` out 1: SRAM request.
- `sram_we_o` out 1: SRAM write enable.
- `sram_addr_o` out $clog2(NumWords): SRAM word address.
- `sram_wdata_o` out DataWidth: SRAM write data.
- `sram_be_o` out DataWidth/8: SRAM byte enables.
- `sram_rdata_i` in DataWidth: SRAM read data, valid 1 cycle after `sram_req_o`.
- `oor_o` out 1: sticky out-of-range flag.
- `req_cnt_o` out 32: granted-request counter, saturating.

## Operation
- **Stall counter.** `stall_cnt` counts 0..StallEvery-1 and wraps; it increments every cycle, independent of `req_i`.
  - `gnt_o = rst_ni && !(StallEvery!=0 && stall_cnt==StallEvery-1)`.
- **Word address.** `waddr = addr_i[AddrWidth-1:$clog2(DataWidth/8)]`. Low address bits are ignored.
- **Range check.** A request is in range iff `waddr < NumWords`.
- **SRAM drive (combinational).** On a granted, in-range request:
  - `sram_req_o = 1`
  - `sram_we_o = we_i`
  - `sram_addr_o = waddr` truncated
  - `sram_wdata_o = wdata_i`
  - `sram_be_o = we_i ? strb_i : '1`
  - Otherwise `sram_req_o = 0`.
- **Out-of-range requests.** Granted but never reach the SRAM. Set `oor_o`, which stays set until reset. Still produce a response.
- **Response pipeline.** RespLatency stages, each carrying `{valid, is_write, oor}`. Stage 1 is loaded on grant.
  - Read data is captured from `sram_rdata_i` into a data pipe when stage 1 is valid.
  - The data pipe has RespLatency-1 further registers.
  - At the last stage: `rvalid_o = valid`. `rdata_o` is zero for writes, DEAD_BEEF for out-of-range reads, and the piped SRAM data otherwise. When not valid, `rdata_o = 0`.
- **Back-to-back requests.** Fully pipelined: one grant per non-stall cycle, unlimited outstanding up to RespLatency. There is no `rready`; upstream always accepts.
- **Request counter.** `req_cnt_o` increments on each grant and saturates at `32'hFFFF_FFFF`.

## Timing
- **Reset.** `rst_ni` low at a clock edge clears `stall_cnt`, all pipeline valids and data, `oor_o` and `req_cnt_o`. While `rst_ni` is low, `gnt_o` and `sram_req_o` are 0.
  - Responses in flight are dropped.
  - The first cycle after release has `gnt_o = 1` unless StallEvery==... (counter is 0, so it stalls only if StallEvery-1==0, which is illegal).
- **Latency.** A grant in cycle T gives `rvalid_o` high in cycle T+RespLatency, for one cycle per grant.
- **Write visibility.** A read granted in cycle T+1 after a write granted in cycle T returns the new data. The SRAM is write-first by ordering.
- **Stall timing.** With StallEvery=N, `gnt_o` is low in cycles N-1, 2N-1, … after reset release. A request held across a stall is granted the next cycle.
- **Strobe-off write.** A request with `strb_i==0` and `we_i=1` is still granted and answered. No SRAM bytes change.

## Test plan
- **Basic latency (RespLatency=1, StallEvery=0).** Write 0x1122334455667788 to addr 0x10, then read addr 0x10. Required: `rvalid_o` 1 cycle after each grant, `rdata_o` 0 for the write and 0x1122334455667788 for the read, `req_cnt_o`=2.
- **Byte strobes.** Write all-ones to 0x20, then write 0 with strb=8'h0F, then read 0x20. Required: read returns 0xFFFFFFFF00000000.
- **Latency and back-to-back (RespLatency=3).** Issue 4 back-to-back reads of preloaded words 0..3. Required: 4 consecutive `rvalid_o` pulses starting 3 cycles after the first grant, with data in request order.
- **Grant stall (StallEvery=4).** Hold `req_i` high for 12 cycles. Required: `gnt_o` low in cycles 3, 7, 11; 9 grants; 9 responses.
- **Out-of-range read.** Read addr = NumWords*8 (word 256). Required: `sram_req_o` stays 0, `rvalid_o` pulses with 0xDEADBEEF, `oor_o` goes high and stays high.
- **Reset mid-flight (RespLatency=4).** Grant 2 reads, then pull `rst_ni` low 2 cycles later. Required: no `rvalid_o` afterwards, `req_cnt_o`=0, `oor_o`=0.
